// File: rtl/crv32_data_ram_port.sv
`default_nettype none
// ============================================================================
// Module      : crv32_data_ram_port
// Description : CPU data RAM port with multi-word lines, byte-lane writes,
//               configurable read latency and a priority debug write port.
// Revision    : 1.0 - initial release
// ============================================================================
module crv32_data_ram_port #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [31:0] BASE_HI  = 32'd0,
    parameter int unsigned WPL      = 2,
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        dbg_mem_op,
    input  logic [31:0] dbg_adr,
    input  logic [31:0] dbg_do,
    input  logic [3:0]  dbg_wren,
    output logic        bus_err
);

    localparam int unsigned c_sel_w      = $clog2(WPL);
    localparam int unsigned c_sel_ws     = (c_sel_w == 0) ? 1 : c_sel_w;
    localparam int unsigned c_line_lsb   = c_sel_w + 2;
    localparam int unsigned c_idx_w      = ADDR_W - c_line_lsb;
    localparam int unsigned c_depth      = 2 ** c_idx_w;
    localparam int unsigned c_line_bytes = 4 * WPL;
    localparam int unsigned c_line_w     = 32 * WPL;
    localparam logic [1:0]  c_lat_load   = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        RESP  = 2'd2,
        WRESP = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_cnt, w_cnt_nxt;
    logic [31:0]         r_rdata, w_rdata_nxt;
    logic [31:0]         r_rd_word, w_rd_word_nxt;
    logic                r_err, w_err_nxt;

    logic [c_line_w-1:0] r_mem [c_depth];

    logic [c_idx_w-1:0]  w_cpu_idx, w_dbg_idx, w_wr_idx;
    logic [c_sel_ws-1:0] w_cpu_sel, w_dbg_sel, w_wr_sel;
    logic [3:0]          w_wr_mask;
    logic [31:0]         w_wr_word;
    logic [c_line_bytes-1:0] w_wr_be;
    logic [c_line_w-1:0] w_wr_data;
    logic                w_wr_en;
    logic [31:0]         w_cpu_word;
    logic                w_in_range, w_accept, w_cpu_wr;

    assign w_cpu_idx = mem_addr[ADDR_W-1:c_line_lsb];
    assign w_dbg_idx = dbg_adr[ADDR_W-1:c_line_lsb];

    generate
        if (WPL == 1) begin : g_sel_single
            assign w_cpu_sel = '0;
            assign w_dbg_sel = '0;
        end else begin : g_sel_multi
            assign w_cpu_sel = mem_addr[c_line_lsb-1:2];
            assign w_dbg_sel = dbg_adr[c_line_lsb-1:2];
        end
    endgenerate

    assign w_in_range = (mem_addr[31:ADDR_W] == BASE_HI[31-ADDR_W:0]);
    assign w_accept   = (r_state == IDLE) && mem_valid && !dbg_mem_op;
    assign w_cpu_wr   = w_accept && w_in_range && (mem_wstrb != 4'b0000);

    always_comb begin
        w_cpu_word = r_mem[w_cpu_idx][31:0];
        for (int w = 1; w < WPL; w++) begin
            if (w_cpu_sel == c_sel_ws'(w)) begin
                w_cpu_word = r_mem[w_cpu_idx][w*32 +: 32];
            end
        end
    end

    // Single write port: the debug master wins whenever it owns the RAM.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_cpu_idx;
        w_wr_sel  = w_cpu_sel;
        w_wr_mask = mem_wstrb;
        w_wr_word = mem_wdata;
        if (dbg_mem_op) begin
            w_wr_en   = |dbg_wren;
            w_wr_idx  = w_dbg_idx;
            w_wr_sel  = w_dbg_sel;
            w_wr_mask = dbg_wren;
            w_wr_word = dbg_do;
        end else if (w_cpu_wr) begin
            w_wr_en = 1'b1;
        end
    end

    always_comb begin
        w_wr_be = '0;
        for (int w = 0; w < WPL; w++) begin
            if (w_wr_sel == c_sel_ws'(w)) begin
                w_wr_be[w*4 +: 4] = w_wr_mask;
            end
        end
    end

    assign w_wr_data = {WPL{w_wr_word}};

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_line_bytes; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rd_word <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rd_word <= w_rd_word_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Read data is captured at acceptance so later debug writes cannot alter it.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rdata_nxt   = r_rdata;
        w_rd_word_nxt = r_rd_word;
        w_err_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_in_range) begin
                        w_state_nxt = RESP;
                        w_rdata_nxt = '0;
                        w_err_nxt   = 1'b1;
                    end else if (mem_wstrb != 4'b0000) begin
                        w_state_nxt = WRESP;
                    end else if (READ_LAT == 1) begin
                        w_state_nxt = RESP;
                        w_rdata_nxt = w_cpu_word;
                    end else begin
                        w_state_nxt   = RWAIT;
                        w_cnt_nxt     = c_lat_load;
                        w_rd_word_nxt = w_cpu_word;
                    end
                end
            end
            RWAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = RESP;
                    w_rdata_nxt = r_rd_word;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            WRESP:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = (r_state == RESP) || (r_state == WRESP);
    assign bus_err   = r_err;

    logic w_unused;
    assign w_unused = &{1'b0, mem_addr[1:0], dbg_adr[31:ADDR_W], dbg_adr[1:0]};

endmodule
`default_nettype wire
